pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Parametrised successor to the fixed 32-bit IF/ID stall register: a generic pipeline stage register with a valid/ready handshake.
- Holds an address/instruction pair in a two-entry elastic buffer (main + skid slot), so upstream ready is purely registered.
- Supports a synchronous flush and drives NOP bubbles when empty.
- Sits between any two pipeline stages; the first instance is IF->ID, the second is ID->EX.

Parameters:
- ADDR_W, 32, width of the address field.
- INST_W, 32, width of the instruction/payload field.
- NOP_VAL, 32'h00000013, value driven on out_inst_o when there is no valid beat (truncated or zero-extended to INST_W).
- RESET_ADDR, 0, out_addr_o value after reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- flush_i  in  1  discard all held and incoming beats.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat; registered.
- in_addr_i  in  ADDR_W  upstream address.
- in_inst_i  in  INST_W  upstream instruction.
- out_valid_o  out  1  downstream beat valid.
- out_ready_i  in  1  downstream accepts the beat.
- out_addr_o  out  ADDR_W  held address.
- out_inst_o  out  INST_W  held instruction, or NOP_VAL when not valid.
- stall_cnt_o  out  32  performance counter (see Optional Feature).
- flush_cnt_o  out  16  performance counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - State EMPTY; out_valid_o=0; in_ready_o=1.
  - out_addr_o=RESET_ADDR; out_inst_o=NOP_VAL; skid slot invalid; counters 0.
  - Reset dominates flush and the handshake in the same cycle.
- Handshake events:
  - Accept = in_valid_i & in_ready_o.
  - Drain = out_valid_o & out_ready_i.
  - Data is registered: an accepted beat appears at the outputs one cycle later at the earliest.
- States:
  - EMPTY: main slot invalid.
  - BUSY: main slot valid, skid slot invalid.
  - FULL: both slots valid.
- Transitions:
  - EMPTY: accept -> BUSY (load main); otherwise stay.
  - BUSY:
    - accept & drain -> BUSY, main reloaded with the new beat.
    - accept & !drain -> FULL, new beat into skid.
    - drain & !accept -> EMPTY.
    - neither -> hold.
  - FULL: in_ready_o=0, so no accept is possible.
    - drain -> BUSY; skid moves into main; skid cleared.
    - no drain -> hold.
- Outputs:
  - in_ready_o = (state != FULL). It is a flop output with no combinational path from out_ready_i.
  - out_valid_o = (state != EMPTY).
  - out_inst_o is forced to NOP_VAL whenever out_valid_o=0.
  - out_addr_o keeps its last value when out_valid_o=0.
- Ordering: strictly FIFO; no beat is ever duplicated or reordered.
- Flush (flush_i=1, rst=0):
  - Next state EMPTY; both slots invalidated.
  - A beat accepted in the flush cycle is discarded.
  - out_addr_o retains its value.
  - The downstream drain in the same cycle still counts as consumed.
  - in_ready_o=1 in the following cycle.
- Payload values are stored verbatim; no arithmetic is performed on them.

Optional Feature:
- Macro: PIPE_STAGE_HS_PERF_EN.
- Defined:
  - stall_cnt_o increments on every cycle with out_valid_o=1 and out_ready_i=0.
  - flush_cnt_o increments on every cycle with flush_i=1.
  - Both counters saturate at all-ones (no wrap) and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package/defines: INST_NOP constant (default NOP_VAL) and the state encoding EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
- Sub-module pipe_slot: valid bit plus {addr, inst} register, with load, clear and synchronous reset. Instantiated twice (main, skid).
- FSM and counters live in pipe_stage_hs.

Test Plan:
- Reset: assert rst for 2 cycles, then release -> out_valid_o=0, in_ready_o=1, out_inst_o=32'h00000013, out_addr_o=0.
- Streaming: drive beats A=(0x100,0xAAAA0001) and B=(0x104,0xAAAA0002) back-to-back with out_ready_i=1 -> A on the outputs 1 cycle after acceptance, B the next cycle, in_ready_o stays 1.
- Backpressure: out_ready_i=0, send 3 beats -> first two accepted, in_ready_o=0 after the second. Raise out_ready_i -> beats drain in order 1,2; in_ready_o=1 a cycle after the first drain; third beat then accepted.
- Flush: in FULL, assert flush_i for 1 cycle with in_valid_i=1 -> next cycle out_valid_o=0, out_inst_o=NOP_VAL, in_ready_o=1; the flushed beat never appears.
- Reset mid-operation: in FULL, pulse rst -> EMPTY next cycle; out_addr_o=RESET_ADDR; no stale beat appears afterwards.
- Counters (PIPE_STAGE_HS_PERF_EN defined): hold out_valid_o=1 with out_ready_i=0 for 5 cycles, then flush twice -> stall_cnt_o=5, flush_cnt_o=2. With the macro undefined, both read 0.

Source files
------------

// File: rtl/pipe_stage_hs_pkg.sv
// Shared constants and state encoding for the handshaked pipeline stage register.
package pipe_stage_hs_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_hs_slot.sv
// One buffer slot: a valid bit plus a payload register; clear drops only the valid bit.
module pipe_slot #(
    parameter int           W       = 64,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    logic         vld_d, vld_q;
    logic [W-1:0] data_d, data_q;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end else if (clear_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= RST_VAL;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Two-entry elastic pipeline stage register (main + skid) with flush and NOP bubbles.
// Perf counters are built only when PIPE_STAGE_HS_PERF_EN is defined.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INST_W     = 32,
    parameter logic [31:0]       NOP_VAL    = INST_NOP,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [INST_W-1:0] in_inst_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [INST_W-1:0] out_inst_o,
    output logic [31:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o
);

    localparam int                DW       = ADDR_W + INST_W;
    localparam logic [INST_W-1:0] NOP_W    = INST_W'(NOP_VAL);
    localparam logic [DW-1:0]     SLOT_RST = {RESET_ADDR, NOP_W};

    state_e        state_d, state_q;
    logic          main_ld, main_clr, main_from_skid, skid_ld, skid_clr;
    logic          main_vld, skid_vld;
    logic [DW-1:0] main_data, skid_data, main_din;
    logic          accept, drain;

    // Outputs come straight from slot flops; they track state_q by construction.
    assign in_ready_o  = ~skid_vld;
    assign out_valid_o = main_vld;
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush_i) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    main_ld = 1'b1;
                    state_d = BUSY;
                end
                BUSY: begin
                    if (accept && drain) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = FULL;
                    end else if (drain) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
                    end
                end
                FULL: if (drain) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                    state_d        = BUSY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    assign main_din = main_from_skid ? skid_data : {in_addr_i, in_inst_i};

    pipe_slot #(.W(DW), .RST_VAL(SLOT_RST)) u_main (
        .clk(clk), .rst(rst), .load_i(main_ld), .clear_i(main_clr),
        .data_i(main_din), .vld_o(main_vld), .data_o(main_data)
    );

    pipe_slot #(.W(DW), .RST_VAL(SLOT_RST)) u_skid (
        .clk(clk), .rst(rst), .load_i(skid_ld), .clear_i(skid_clr),
        .data_i({in_addr_i, in_inst_i}), .vld_o(skid_vld), .data_o(skid_data)
    );

    assign out_addr_o = main_data[DW-1:INST_W];
    assign out_inst_o = main_vld ? main_data[INST_W-1:0] : NOP_W;

`ifdef PIPE_STAGE_HS_PERF_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [15:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_o && !out_ready_i && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_i && flush_cnt_q != '1)                     flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: queue-based model checked every cycle plus directed literal checks.
module tb_pipe_stage_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [31:0] in_addr_i = '0, in_inst_i = '0;
    logic        in_ready_o, out_valid_o;
    logic [31:0] out_addr_o, out_inst_o, stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int nvec = 0, nerr = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_hs dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_addr_i(in_addr_i), .in_inst_i(in_inst_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_inst_o(out_inst_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    typedef struct { logic [31:0] a; logic [31:0] i; } beat_t;
    beat_t       mq[$];
    logic [31:0] drained[$];
    logic [31:0] m_addr = '0;
    int unsigned m_stall = 0, m_flush = 0;

    // Model: the stage is a FIFO of depth 2 whose head is what the outputs show.
    always @(posedge clk) begin
        logic acc, drn;
        acc = in_valid_i && (mq.size() < 2);
        drn = (mq.size() > 0) && out_ready_i;
        if (rst) begin
            mq.delete();
            m_addr  = '0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (mq.size() > 0 && !out_ready_i) m_stall++;
            if (flush_i) m_flush++;
            if (drn) drained.push_back(mq[0].a);
            if (flush_i) mq.delete();
            else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back('{in_addr_i, in_inst_i});
            end
            if (mq.size() > 0) m_addr = mq[0].a;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", {31'd0, out_valid_o}, (mq.size() > 0) ? 32'd1 : 32'd0);
            chk("m_ready", {31'd0, in_ready_o},  (mq.size() < 2) ? 32'd1 : 32'd0);
            chk("m_inst",  out_inst_o, (mq.size() > 0) ? mq[0].i : 32'h0000_0013);
            chk("m_addr",  out_addr_o, m_addr);
`ifdef PIPE_STAGE_HS_PERF_EN
            chk("m_stall", stall_cnt_o, m_stall);
            chk("m_flush", {16'd0, flush_cnt_o}, m_flush);
`else
            chk("m_stall", stall_cnt_o, 32'd0);
            chk("m_flush", {16'd0, flush_cnt_o}, 32'd0);
`endif
        end
    end

    task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] i,
                       input logic r, input logic f, input logic rs);
        in_valid_i  = v;
        in_addr_i   = a;
        in_inst_i   = i;
        out_ready_i = r;
        flush_i     = f;
        rst         = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_drained [6];
        exp_drained = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h208, 32'h500};

        // Reset for two cycles
        drv(0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_inst", out_inst_o, 32'h0000_0013);
        chk("rst_addr", out_addr_o, 32'h0);

        // Streaming
        drv(1, 32'h100, 32'hAAAA_0001, 1, 0, 0);
        chk("str_addrA", out_addr_o, 32'h100);
        chk("str_instA", out_inst_o, 32'hAAAA_0001);
        chk("str_readyA", {31'd0, in_ready_o}, 32'd1);
        drv(1, 32'h104, 32'hAAAA_0002, 1, 0, 0);
        chk("str_addrB", out_addr_o, 32'h104);
        chk("str_instB", out_inst_o, 32'hAAAA_0002);
        drv(0, 0, 0, 1, 0, 0);
        chk("str_empty", {31'd0, out_valid_o}, 32'd0);
        drv(0, 0, 0, 1, 0, 0);

        // Backpressure
        drv(1, 32'h200, 32'hBBBB_0001, 0, 0, 0);
        drv(1, 32'h204, 32'hBBBB_0002, 0, 0, 0);
        chk("bp_ready0", {31'd0, in_ready_o}, 32'd0);
        chk("bp_head", out_addr_o, 32'h200);
        drv(1, 32'h208, 32'hBBBB_0003, 0, 0, 0);
        chk("bp_hold", out_addr_o, 32'h200);
        drv(1, 32'h208, 32'hBBBB_0003, 1, 0, 0);
        chk("bp_ready1", {31'd0, in_ready_o}, 32'd1);
        chk("bp_second", out_inst_o, 32'hBBBB_0002);
        drv(1, 32'h208, 32'hBBBB_0003, 1, 0, 0);
        chk("bp_third", out_inst_o, 32'hBBBB_0003);
        drv(0, 0, 0, 1, 0, 0);
        chk("bp_drained", {31'd0, out_valid_o}, 32'd0);
        chk("bp_keepaddr", out_addr_o, 32'h208);

        // Flush from FULL with an incoming beat
        drv(1, 32'h300, 32'hCCCC_0001, 0, 0, 0);
        drv(1, 32'h304, 32'hCCCC_0002, 0, 0, 0);
        chk("fl_full", {31'd0, in_ready_o}, 32'd0);
        drv(1, 32'h308, 32'hCCCC_0003, 0, 1, 0);
        chk("fl_valid", {31'd0, out_valid_o}, 32'd0);
        chk("fl_inst", out_inst_o, 32'h0000_0013);
        chk("fl_ready", {31'd0, in_ready_o}, 32'd1);
        chk("fl_addr", out_addr_o, 32'h300);
        drv(0, 0, 0, 1, 0, 0);

        // Reset mid-operation
        drv(1, 32'h400, 32'hDDDD_0001, 0, 0, 0);
        drv(1, 32'h404, 32'hDDDD_0002, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 1);
        chk("mr_addr", out_addr_o, 32'h0);
        chk("mr_valid", {31'd0, out_valid_o}, 32'd0);
        drv(0, 0, 0, 1, 0, 0);
        drv(0, 0, 0, 1, 0, 0);
        chk("mr_nostale", {31'd0, out_valid_o}, 32'd0);

        // Counters
        drv(0, 0, 0, 0, 0, 1);
        drv(1, 32'h500, 32'hEEEE_0001, 0, 0, 0);
        repeat (5) drv(0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 1, 0);
        drv(0, 0, 0, 1, 1, 0);
        drv(0, 0, 0, 1, 0, 0);
`ifdef PIPE_STAGE_HS_PERF_EN
        chk("cnt_stall", stall_cnt_o, 32'd5);
        chk("cnt_flush", {16'd0, flush_cnt_o}, 32'd2);
`else
        chk("cnt_stall", stall_cnt_o, 32'd0);
        chk("cnt_flush", {16'd0, flush_cnt_o}, 32'd0);
`endif

        // Consumed beats, in order, with no flushed or reset-killed beat
        chk("drain_count", drained.size(), 32'd6);
        for (int k = 0; k < 6; k++)
            chk("drain_order", (k < drained.size()) ? drained[k] : 32'hFFFF_FFFF, exp_drained[k]);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
